// File: rtl/cv32e40p_apu_arbiter.sv
// Round-robin arbiter sharing one APU/FPU between several cores.
// In-order responses are routed back through an ID FIFO with a parity bit per entry.
module cv32e40p_apu_arbiter #(
    parameter int NUM_CORES        = 4,
    parameter int APU_NARGS_CPU    = 3,
    parameter int APU_WOP_CPU      = 6,
    parameter int APU_NDSFLAGS_CPU = 15,
    parameter int APU_NUSFLAGS_CPU = 5,
    parameter int MAX_OUTSTANDING  = 4
) (
    input  logic                                             clk_i,
    input  logic                                             rst_ni,
    input  logic [NUM_CORES-1:0]                             core_apu_req_i,
    output logic [NUM_CORES-1:0]                             core_apu_gnt_o,
    input  logic [NUM_CORES-1:0][APU_NARGS_CPU-1:0][31:0]    core_apu_operands_i,
    input  logic [NUM_CORES-1:0][APU_WOP_CPU-1:0]            core_apu_op_i,
    input  logic [NUM_CORES-1:0][APU_NDSFLAGS_CPU-1:0]       core_apu_flags_i,
    output logic [NUM_CORES-1:0]                             core_apu_rvalid_o,
    output logic [31:0]                                      core_apu_result_o,
    output logic [APU_NUSFLAGS_CPU-1:0]                      core_apu_flags_o,
    output logic                                             apu_req_o,
    input  logic                                             apu_gnt_i,
    output logic [APU_NARGS_CPU-1:0][31:0]                   apu_operands_o,
    output logic [APU_WOP_CPU-1:0]                           apu_op_o,
    output logic [APU_NDSFLAGS_CPU-1:0]                      apu_flags_o,
    input  logic                                             apu_rvalid_i,
    input  logic [31:0]                                      apu_result_i,
    input  logic [APU_NUSFLAGS_CPU-1:0]                      apu_flags_i,
    output logic [$clog2(MAX_OUTSTANDING):0]                 outstanding_o,
    output logic                                             err_o
);

    localparam int IDX_W = $clog2(NUM_CORES);
    localparam int PTR_W = $clog2(MAX_OUTSTANDING);
    localparam int CNT_W = PTR_W + 1;

    function automatic logic id_parity(input logic [IDX_W-1:0] id);
        return ^id;
    endfunction

    // First requester at or after ptr, wrapping modulo NUM_CORES; ptr when nobody requests.
    function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_CORES-1:0] req,
                                                 input logic [IDX_W-1:0]     ptr);
        logic [IDX_W-1:0] pick;
        logic [IDX_W-1:0] cand;
        logic             found;
        pick  = ptr;
        found = 1'b0;
        for (int k = 0; k < NUM_CORES; k++) begin
            cand = IDX_W'((int'(ptr) + k) % NUM_CORES);
            if (!found && req[cand]) begin
                pick  = cand;
                found = 1'b1;
            end else begin
                pick  = pick;
                found = found;
            end
        end
        return pick;
    endfunction

    logic [IDX_W-1:0] rr_ptr_r;
    logic             lock_valid_r;
    logic [IDX_W-1:0] lock_idx_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [PTR_W-1:0] rd_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             err_r;
    logic [IDX_W-1:0] id_mem_r  [MAX_OUTSTANDING];
    logic             par_mem_r [MAX_OUTSTANDING];

    logic [IDX_W-1:0] sel_s;
    logic [IDX_W-1:0] rr_next_s;
    logic [IDX_W-1:0] head_s;
    logic             fifo_full_s;
    logic             fifo_empty_s;
    logic             handshake_s;
    logic             push_s;
    logic             pop_s;
    logic             spurious_s;
    logic             lock_drop_s;
    logic             parity_err_s;

    // A pending (locked) request keeps priority over the round-robin search.
    always_comb begin
        sel_s = rr_pick(core_apu_req_i, rr_ptr_r);
        if (lock_valid_r) begin
            sel_s = lock_idx_r;
        end else begin
            sel_s = sel_s;
        end
    end

    // Request path: selected core's fields, request gated by FIFO space.
    always_comb begin
        fifo_full_s    = (count_r == CNT_W'(MAX_OUTSTANDING));
        fifo_empty_s   = (count_r == {CNT_W{1'b0}});
        apu_req_o      = core_apu_req_i[sel_s] && !fifo_full_s;
        apu_operands_o = core_apu_operands_i[sel_s];
        apu_op_o       = core_apu_op_i[sel_s];
        apu_flags_o    = core_apu_flags_i[sel_s];
        handshake_s    = apu_req_o && apu_gnt_i;
        push_s         = handshake_s;
        if (sel_s == IDX_W'(NUM_CORES - 1)) begin
            rr_next_s = {IDX_W{1'b0}};
        end else begin
            rr_next_s = sel_s + IDX_W'(1);
        end
        core_apu_gnt_o        = {NUM_CORES{1'b0}};
        core_apu_gnt_o[sel_s] = handshake_s;
    end

    // Response path: route rvalid to the oldest outstanding ID and flag protocol errors.
    always_comb begin
        head_s            = id_mem_r[rd_ptr_r];
        pop_s             = apu_rvalid_i && !fifo_empty_s;
        spurious_s        = apu_rvalid_i && fifo_empty_s;
        parity_err_s      = pop_s && (par_mem_r[rd_ptr_r] != id_parity(head_s));
        lock_drop_s       = lock_valid_r && !core_apu_req_i[lock_idx_r];
        core_apu_rvalid_o = {NUM_CORES{1'b0}};
        core_apu_rvalid_o[head_s] = pop_s;
        core_apu_result_o = apu_result_i;
        core_apu_flags_o  = apu_flags_i;
    end

    // Arbitration state: round-robin pointer and request lock.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            rr_ptr_r     <= {IDX_W{1'b0}};
            lock_valid_r <= 1'b0;
            lock_idx_r   <= {IDX_W{1'b0}};
        end else begin
            if (handshake_s) begin
                rr_ptr_r <= rr_next_s;
            end else begin
                rr_ptr_r <= rr_ptr_r;
            end
            if (lock_drop_s || handshake_s) begin
                lock_valid_r <= 1'b0;
                lock_idx_r   <= lock_idx_r;
            end else if (apu_req_o && !apu_gnt_i) begin
                lock_valid_r <= 1'b1;
                lock_idx_r   <= sel_s;
            end else begin
                lock_valid_r <= lock_valid_r;
                lock_idx_r   <= lock_idx_r;
            end
        end
    end

    // ID FIFO control, occupancy and sticky error.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            err_r    <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_W'(1);
            end else begin
                wr_ptr_r <= wr_ptr_r;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_W'(1);
            end else begin
                rd_ptr_r <= rd_ptr_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
            err_r <= err_r | spurious_s | lock_drop_s | parity_err_s;
        end
    end

    // ID FIFO storage; entries are only read while occupied, so no reset is needed.
    always_ff @(posedge clk_i) begin
        if (push_s) begin
            id_mem_r[wr_ptr_r]  <= sel_s;
            par_mem_r[wr_ptr_r] <= id_parity(sel_s);
        end else begin
            id_mem_r[wr_ptr_r]  <= id_mem_r[wr_ptr_r];
            par_mem_r[wr_ptr_r] <= par_mem_r[wr_ptr_r];
        end
    end

    assign outstanding_o = count_r;
    assign err_o         = err_r;

endmodule

// File: tb/tb_cv32e40p_apu_arbiter.sv
// Directed-vector bench for cv32e40p_apu_arbiter with hand-computed expectations.
module tb_cv32e40p_apu_arbiter;

    localparam int NC  = 4;
    localparam int NA  = 3;
    localparam int WOP = 6;
    localparam int NDS = 15;
    localparam int NUS = 5;
    localparam int MO  = 4;

    logic                          clk = 1'b0;
    logic                          rst_ni;
    logic [NC-1:0]                 core_apu_req_i;
    logic [NC-1:0]                 core_apu_gnt_o;
    logic [NC-1:0][NA-1:0][31:0]   core_apu_operands_i;
    logic [NC-1:0][WOP-1:0]        core_apu_op_i;
    logic [NC-1:0][NDS-1:0]        core_apu_flags_i;
    logic [NC-1:0]                 core_apu_rvalid_o;
    logic [31:0]                   core_apu_result_o;
    logic [NUS-1:0]                core_apu_flags_o;
    logic                          apu_req_o;
    logic                          apu_gnt_i;
    logic [NA-1:0][31:0]           apu_operands_o;
    logic [WOP-1:0]                apu_op_o;
    logic [NDS-1:0]                apu_flags_o;
    logic                          apu_rvalid_i;
    logic [31:0]                   apu_result_i;
    logic [NUS-1:0]                apu_flags_i;
    logic [$clog2(MO):0]           outstanding_o;
    logic                          err_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cv32e40p_apu_arbiter #(
        .NUM_CORES(NC), .APU_NARGS_CPU(NA), .APU_WOP_CPU(WOP),
        .APU_NDSFLAGS_CPU(NDS), .APU_NUSFLAGS_CPU(NUS), .MAX_OUTSTANDING(MO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .core_apu_req_i(core_apu_req_i), .core_apu_gnt_o(core_apu_gnt_o),
        .core_apu_operands_i(core_apu_operands_i), .core_apu_op_i(core_apu_op_i),
        .core_apu_flags_i(core_apu_flags_i), .core_apu_rvalid_o(core_apu_rvalid_o),
        .core_apu_result_o(core_apu_result_o), .core_apu_flags_o(core_apu_flags_o),
        .apu_req_o(apu_req_o), .apu_gnt_i(apu_gnt_i),
        .apu_operands_o(apu_operands_o), .apu_op_o(apu_op_o), .apu_flags_o(apu_flags_o),
        .apu_rvalid_i(apu_rvalid_i), .apu_result_i(apu_result_i), .apu_flags_i(apu_flags_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_reset();
        rst_ni         = 1'b0;
        core_apu_req_i = 4'b0000;
        apu_gnt_i      = 1'b0;
        apu_rvalid_i   = 1'b0;
        apu_result_i   = 32'h0;
        apu_flags_i    = 5'h0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        #1;
        check_eq("rst.req", 32'(apu_req_o), 32'h0);
        check_eq("rst.gnt", 32'(core_apu_gnt_o), 32'h0);
        check_eq("rst.rv",  32'(core_apu_rvalid_o), 32'h0);
        check_eq("rst.out", 32'(outstanding_o), 32'h0);
        check_eq("rst.err", 32'(err_o), 32'h0);
    endtask

    // Apply one cycle of stimulus, check outputs before the edge, then advance.
    task automatic vec(input string tag, input logic [3:0] req, input logic gnt,
                       input logic rv, input logic [31:0] res, input logic e_req,
                       input int e_sel, input logic [3:0] e_gnt, input logic [3:0] e_rv,
                       input int e_out, input logic e_err);
        core_apu_req_i = req;
        apu_gnt_i      = gnt;
        apu_rvalid_i   = rv;
        apu_result_i   = res;
        apu_flags_i    = res[4:0];
        #1;
        check_eq({tag, ".req"}, 32'(apu_req_o), 32'(e_req));
        check_eq({tag, ".gnt"}, 32'(core_apu_gnt_o), 32'(e_gnt));
        check_eq({tag, ".rv"},  32'(core_apu_rvalid_o), 32'(e_rv));
        check_eq({tag, ".out"}, 32'(outstanding_o), 32'(e_out));
        check_eq({tag, ".err"}, 32'(err_o), 32'(e_err));
        if (e_req) begin
            check_eq({tag, ".op"},  32'(apu_op_o), 32'(e_sel + 1));
            check_eq({tag, ".opd"}, apu_operands_o[1], 32'(e_sel * 16 + 1));
        end
        if (rv) begin
            check_eq({tag, ".res"}, core_apu_result_o, res);
            check_eq({tag, ".flg"}, 32'(core_apu_flags_o), 32'(res[4:0]));
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        for (int c = 0; c < NC; c++) begin
            core_apu_op_i[c]    = WOP'(c + 1);
            core_apu_flags_i[c] = NDS'(c + 3);
            for (int a = 0; a < NA; a++) begin
                core_apu_operands_i[c][a] = 32'(c * 16 + a);
            end
        end
        do_reset();

        // All cores request, grant always high; each rvalid retires the previous grant.
        vec("A0", 4'b1111, 1'b1, 1'b0, 32'h0,  1'b1, 0, 4'b0001, 4'b0000, 0, 1'b0);
        vec("A1", 4'b1111, 1'b1, 1'b1, 32'h11, 1'b1, 1, 4'b0010, 4'b0001, 1, 1'b0);
        vec("A2", 4'b1111, 1'b1, 1'b1, 32'h12, 1'b1, 2, 4'b0100, 4'b0010, 1, 1'b0);
        vec("A3", 4'b1111, 1'b1, 1'b1, 32'h13, 1'b1, 3, 4'b1000, 4'b0100, 1, 1'b0);
        vec("A4", 4'b1111, 1'b1, 1'b1, 32'h14, 1'b1, 0, 4'b0001, 4'b1000, 1, 1'b0);
        vec("A5", 4'b1111, 1'b1, 1'b1, 32'h15, 1'b1, 1, 4'b0010, 4'b0001, 1, 1'b0);
        vec("A6", 4'b0000, 1'b0, 1'b1, 32'h16, 1'b0, 0, 4'b0000, 4'b0010, 1, 1'b0);
        do_reset();

        // Core 2 locked while core 0 (higher priority from rr_ptr=0) joins.
        vec("B0", 4'b0100, 1'b0, 1'b0, 32'h0,  1'b1, 2, 4'b0000, 4'b0000, 0, 1'b0);
        vec("B1", 4'b0101, 1'b0, 1'b0, 32'h0,  1'b1, 2, 4'b0000, 4'b0000, 0, 1'b0);
        vec("B2", 4'b0101, 1'b0, 1'b0, 32'h0,  1'b1, 2, 4'b0000, 4'b0000, 0, 1'b0);
        vec("B3", 4'b0101, 1'b1, 1'b0, 32'h0,  1'b1, 2, 4'b0100, 4'b0000, 0, 1'b0);
        vec("B4", 4'b0001, 1'b1, 1'b0, 32'h0,  1'b1, 0, 4'b0001, 4'b0000, 1, 1'b0);
        vec("B5", 4'b0000, 1'b0, 1'b1, 32'h21, 1'b0, 0, 4'b0000, 4'b0100, 2, 1'b0);
        vec("B6", 4'b0000, 1'b0, 1'b1, 32'h22, 1'b0, 0, 4'b0000, 4'b0001, 1, 1'b0);
        vec("B7", 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 0, 1'b0);

        // Fill the FIFO, blocked while full, resume after one pop, then drain.
        vec("C0",  4'b1111, 1'b1, 1'b0, 32'h0,  1'b1, 1, 4'b0010, 4'b0000, 0, 1'b0);
        vec("C1",  4'b1111, 1'b1, 1'b0, 32'h0,  1'b1, 2, 4'b0100, 4'b0000, 1, 1'b0);
        vec("C2",  4'b1111, 1'b1, 1'b0, 32'h0,  1'b1, 3, 4'b1000, 4'b0000, 2, 1'b0);
        vec("C3",  4'b1111, 1'b1, 1'b0, 32'h0,  1'b1, 0, 4'b0001, 4'b0000, 3, 1'b0);
        vec("C4",  4'b1111, 1'b1, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 4, 1'b0);
        vec("C5",  4'b1111, 1'b1, 1'b1, 32'h31, 1'b0, 0, 4'b0000, 4'b0010, 4, 1'b0);
        vec("C6",  4'b1111, 1'b1, 1'b0, 32'h0,  1'b1, 1, 4'b0010, 4'b0000, 3, 1'b0);
        vec("C7",  4'b0000, 1'b0, 1'b1, 32'h32, 1'b0, 0, 4'b0000, 4'b0100, 4, 1'b0);
        vec("C8",  4'b0000, 1'b0, 1'b1, 32'h33, 1'b0, 0, 4'b0000, 4'b1000, 3, 1'b0);
        vec("C9",  4'b0000, 1'b0, 1'b1, 32'h34, 1'b0, 0, 4'b0000, 4'b0001, 2, 1'b0);
        vec("C10", 4'b0000, 1'b0, 1'b1, 32'h35, 1'b0, 0, 4'b0000, 4'b0010, 1, 1'b0);
        vec("C11", 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 0, 1'b0);

        // Grants to 1,3,1 then in-order responses 0xA,0xB,0xC.
        vec("D0", 4'b0010, 1'b1, 1'b0, 32'h0, 1'b1, 1, 4'b0010, 4'b0000, 0, 1'b0);
        vec("D1", 4'b1000, 1'b1, 1'b0, 32'h0, 1'b1, 3, 4'b1000, 4'b0000, 1, 1'b0);
        vec("D2", 4'b0010, 1'b1, 1'b0, 32'h0, 1'b1, 1, 4'b0010, 4'b0000, 2, 1'b0);
        vec("D3", 4'b0000, 1'b0, 1'b1, 32'hA, 1'b0, 0, 4'b0000, 4'b0010, 3, 1'b0);
        vec("D4", 4'b0000, 1'b0, 1'b1, 32'hB, 1'b0, 0, 4'b0000, 4'b1000, 2, 1'b0);
        vec("D5", 4'b0000, 1'b0, 1'b1, 32'hC, 1'b0, 0, 4'b0000, 4'b0010, 1, 1'b0);
        vec("D6", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 0, 4'b0000, 4'b0000, 0, 1'b0);

        // Simultaneous push and pop at occupancy 2.
        vec("E0", 4'b0100, 1'b1, 1'b0, 32'h0,  1'b1, 2, 4'b0100, 4'b0000, 0, 1'b0);
        vec("E1", 4'b1000, 1'b1, 1'b0, 32'h0,  1'b1, 3, 4'b1000, 4'b0000, 1, 1'b0);
        vec("E2", 4'b0001, 1'b1, 1'b1, 32'h51, 1'b1, 0, 4'b0001, 4'b0100, 2, 1'b0);
        vec("E3", 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 2, 1'b0);
        vec("E4", 4'b0000, 1'b0, 1'b1, 32'h52, 1'b0, 0, 4'b0000, 4'b1000, 2, 1'b0);
        vec("E5", 4'b0000, 1'b0, 1'b1, 32'h53, 1'b0, 0, 4'b0000, 4'b0001, 1, 1'b0);
        vec("E6", 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 0, 1'b0);

        // Spurious rvalid on empty FIFO: sticky error, cleared by reset.
        vec("F0", 4'b0000, 1'b0, 1'b1, 32'h61, 1'b0, 0, 4'b0000, 4'b0000, 0, 1'b0);
        vec("F1", 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 0, 1'b1);
        vec("F2", 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 0, 1'b1);
        do_reset();

        // Request dropped while locked.
        vec("G0", 4'b0010, 1'b0, 1'b0, 32'h0, 1'b1, 1, 4'b0000, 4'b0000, 0, 1'b0);
        vec("G1", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 0, 4'b0000, 4'b0000, 0, 1'b0);
        vec("G2", 4'b0000, 1'b0, 1'b0, 32'h0, 1'b0, 0, 4'b0000, 4'b0000, 0, 1'b1);
        do_reset();

        // Reset discards an in-flight ID; the late response is an error.
        vec("H0", 4'b0001, 1'b1, 1'b0, 32'h0,  1'b1, 0, 4'b0001, 4'b0000, 0, 1'b0);
        do_reset();
        vec("H1", 4'b0000, 1'b0, 1'b1, 32'h71, 1'b0, 0, 4'b0000, 4'b0000, 0, 1'b0);
        vec("H2", 4'b0000, 1'b0, 1'b0, 32'h0,  1'b0, 0, 4'b0000, 4'b0000, 0, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cv32e40p_apu_arbiter.md
CV32E40P_APU_ARBITER -- requirements
Module: cv32e40p_apu_arbiter

Interface
REQ-001 The block SHALL have the following parameters, one per line: name, default, meaning.
- NUM_CORES, 4: number of requesting cores; 2..8.
- APU_NARGS_CPU, 3: operands per request.
- APU_WOP_CPU, 6: opcode width.
- APU_NDSFLAGS_CPU, 15: downstream flag width.
- APU_NUSFLAGS_CPU, 5: upstream flag width.
- MAX_OUTSTANDING, 4: depth of the response-ID FIFO; power of 2, 2..16.
REQ-002 The block SHALL have the following ports, one per line: name, direction, width, meaning.
- clk_i, in, 1: single clock.
- rst_ni, in, 1: reset, synchronous, active-low.
- core_apu_req_i, in, NUM_CORES: per-core request.
- core_apu_gnt_o, out, NUM_CORES: per-core grant.
- core_apu_operands_i, in, NUM_CORES x APU_NARGS_CPU x 32: per-core operands.
- core_apu_op_i, in, NUM_CORES x APU_WOP_CPU: per-core opcode.
- core_apu_flags_i, in, NUM_CORES x APU_NDSFLAGS_CPU: per-core downstream flags.
- core_apu_rvalid_o, out, NUM_CORES: per-core response valid.
- core_apu_result_o, out, 32: result, broadcast to all cores.
- core_apu_flags_o, out, APU_NUSFLAGS_CPU: upstream flags, broadcast to all cores.
- apu_req_o, out, 1: request to the shared APU/FPU.
- apu_gnt_i, in, 1: grant from the APU.
- apu_operands_o, out, APU_NARGS_CPU x 32: selected operands.
- apu_op_o, out, APU_WOP_CPU: selected opcode.
- apu_flags_o, out, APU_NDSFLAGS_CPU: selected downstream flags.
- apu_rvalid_i, in, 1: APU response valid.
- apu_result_i, in, 32: APU result.
- apu_flags_i, in, APU_NUSFLAGS_CPU: APU upstream flags.
- outstanding_o, out, $clog2(MAX_OUTSTANDING)+1: number of in-flight requests.
- err_o, out, 1: sticky protocol error.

Function
REQ-003 Arbitration SHALL be round-robin: the search starts at index rr_ptr and wraps modulo NUM_CORES; the first requesting core is selected.
REQ-004 rr_ptr SHALL update to (granted index + 1) mod NUM_CORES only in a handshake cycle (apu_req_o && apu_gnt_i).
REQ-005 Request stability: if apu_req_o=1 and apu_gnt_i=0, a lock register SHALL hold the selected index, and the same core SHALL be presented on the next cycles until its grant, even if higher-priority requests appear.
REQ-006 apu_req_o SHALL equal core_apu_req_i[sel] && !fifo_full; apu_operands_o, apu_op_o and apu_flags_o SHALL be the selected core's fields (combinational mux).
REQ-007 core_apu_gnt_o[sel] SHALL equal apu_gnt_i && apu_req_o; all other grant bits SHALL be 0. Grant latency is zero cycles relative to apu_gnt_i.
REQ-008 On each handshake, sel SHALL be pushed into the ID FIFO.
REQ-009 Responses are in order. On apu_rvalid_i with the FIFO non-empty, core_apu_rvalid_o[head] SHALL be 1 in the same cycle, the other bits 0, and the head SHALL pop.
REQ-010 core_apu_result_o and core_apu_flags_o SHALL pass apu_result_i and apu_flags_i through combinationally.
REQ-011 Simultaneous push and pop SHALL leave the occupancy unchanged; pointers SHALL wrap modulo MAX_OUTSTANDING.
REQ-012 When occupancy equals MAX_OUTSTANDING, apu_req_o SHALL be 0, even in a cycle that pops. The lock register SHALL be retained.
REQ-013 apu_rvalid_i with the FIFO empty SHALL drive no core rvalid and SHALL set err_o, which stays 1 until reset.
REQ-014 The APU SHALL NOT return rvalid in the same cycle as the grant of that request; the minimum latency is one cycle.
REQ-015 outstanding_o SHALL equal the registered FIFO occupancy.
REQ-016 A core dropping its request while locked is an error: err_o SHALL be set and the lock released.

Reset
REQ-017 While rst_ni=0 at a rising edge of clk_i, the block SHALL clear rr_ptr, the lock, the FIFO pointers and occupancy, and err_o.
REQ-018 During and after reset, apu_req_o, core_apu_gnt_o, core_apu_rvalid_o, outstanding_o and err_o SHALL be 0 until new inputs arrive.
REQ-019 Reset asserted mid-operation SHALL discard all in-flight IDs; a later apu_rvalid_i SHALL set err_o.

Verification
REQ-020 All four cores request with apu_gnt_i=1 constantly -> grants in the order 0,1,2,3,0; rr_ptr returns to 1.
REQ-021 Core 2 requests, apu_gnt_i=0 for 3 cycles, core 0 raises its request at cycle 1 -> apu_req_o stays on core 2; gnt[2] fires at cycle 3, then core 0 is served.
REQ-022 MAX_OUTSTANDING=4, four grants with no rvalid -> outstanding_o=4 and apu_req_o=0; one rvalid -> rvalid routed to the first granted core, outstanding_o=3 and requests resume the next cycle.
REQ-023 Grants to cores 1,3,1, then rvalid in 3 consecutive cycles with results 0xA,0xB,0xC -> rvalid on cores 1,3,1 with those results.
REQ-024 apu_rvalid_i=1 with the FIFO empty -> no core rvalid, err_o=1 and stays 1; rst_ni=0 for 1 cycle -> err_o=0.
REQ-025 Same-cycle push and pop at occupancy 2 -> outstanding_o stays 2; FIFO order is preserved across pointer wrap.
